game_session_ctrl: RTL and testbench
====================================

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clock cycles per one-second timer tick.
REQ-002 Parameter ROUND_SEC, default 60, seconds per player turn; legal range 1..2^TIME_W-1.
REQ-003 Parameter TIME_W, default 16, width of time_left.
REQ-004 Parameter SCORE_W, default 16, width of each player score.
REQ-005 Parameter NUM_PLAYERS, default 2, number of players; legal range 1..8.
REQ-006 Port clock, input, 1, the only clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high reset.
REQ-008 Port start, input, 1, synchronous level, sampled each cycle; begins a game or the next turn.
REQ-009 Port increment_score, input, 1, asynchronous score pulse from the Arduino.
REQ-010 Port game_active, output, 1, high only in PLAYING.
REQ-011 Port time_left, output, TIME_W, seconds remaining in the current turn.
REQ-012 Port player_idx, output, PW = max(1, clog2(NUM_PLAYERS)), current player.
REQ-013 Port score, output, SCORE_W, score of player_idx.
REQ-014 Port scores_flat, output, NUM_PLAYERS*SCORE_W, player p at bits [p*SCORE_W +: SCORE_W].
REQ-015 Port game_over, output, 1, high only in GAME_OVER.
REQ-016 Port winner_idx, output, PW, highest-scoring player; lowest index on a tie; valid while game_over is high.
REQ-017 Port high_score, output, SCORE_W, best final score since reset.

Function
REQ-018 The FSM states shall be IDLE, PLAYING, TURN_END and GAME_OVER.
REQ-019 start in IDLE or GAME_OVER shall enter PLAYING next cycle with: all scores 0, player_idx 0, time_left = ROUND_SEC, prescaler 0.
REQ-020 start in PLAYING shall be ignored.
REQ-021 In PLAYING the prescaler shall count 0..TICK_DIV-1; at TICK_DIV-1 it wraps and time_left decrements by 1.
REQ-022 When a tick takes time_left from 1 to 0: go to TURN_END if player_idx < NUM_PLAYERS-1, else to GAME_OVER.
REQ-023 start in TURN_END shall enter PLAYING with player_idx+1, time_left = ROUND_SEC and prescaler 0; scores are preserved.
REQ-024 increment_score shall pass through a two-flop synchronizer plus a rising-edge detector; score updates on the 3rd rising clock edge after the input rises.
REQ-025 Each detected edge in PLAYING shall add 1 to the current player's score, saturating at 2^SCORE_W-1.
REQ-026 Detected edges outside PLAYING shall be discarded.
REQ-027 An edge detected in the same cycle as the final tick shall be counted.
REQ-028 A held-high increment_score shall count once.
REQ-029 winner_idx shall be registered on entry to GAME_OVER.

Reset
REQ-030 Reset shall force: state IDLE, game_active 0, game_over 0, time_left 0, player_idx 0, all scores 0, winner_idx 0, high_score 0, prescaler 0, synchronizer flops 0.
REQ-031 Reset asserted mid-turn shall abort the game immediately, with no score retained.

Configuration
REQ-032 Macro GAME_HIGH_SCORE_EN defined: on entry to GAME_OVER, high_score loads the winner's score if it exceeds high_score; high_score holds across start and clears only on reset.
REQ-033 Macro GAME_HIGH_SCORE_EN undefined: the high_score port remains and is driven constant 0; no high-score register is built.

Structure
REQ-034 A shared package game_pkg shall hold the FSM state enum type and constant ST_W.
REQ-035 A sub-module pulse_sync shall implement the synchronizer and edge detector: ports clock, reset, async_in, pulse_out.
REQ-036 The prescaler, timer, score array and winner compare shall stay in game_session_ctrl.

Verification (TICK_DIV=4, ROUND_SEC=3, SCORE_W=4, NUM_PLAYERS=2)
REQ-037 Reset, then start pulse -> game_active=1, time_left=3; after 4 cycles 2; after 12 cycles TURN_END with time_left=0 and game_active=0.
REQ-038 Five isolated increment_score pulses in turn 0, then start, then two pulses in turn 1 -> scores_flat=0x25 at GAME_OVER, winner_idx=0, high_score=5 (macro defined) or 0 (undefined).
REQ-039 Twenty pulses in one turn -> score saturates at 15 with no wrap.
REQ-040 Pulse timed to be detected on the final tick cycle -> counted; a pulse in TURN_END -> ignored; increment_score held high for 10 cycles -> +1 only.
REQ-041 Reset asserted mid-PLAYING with score 3 -> all outputs return to reset values within the same cycle; high_score unchanged only by completed games.
REQ-042 Second game scoring 3 after a first game scoring 5 -> high_score stays 5; a third game scoring 7 -> high_score=7.

Source files
------------

// File: rtl/game_session_ctrl_pkg.sv
// game_pkg: shared FSM state type and index-width helper for the game session controller
package game_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {ST_IDLE, ST_PLAYING, ST_TURN_END, ST_GAME_OVER} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/game_session_ctrl_if.sv
// game_session_ctrl_if: control inputs and status outputs of the game session controller
interface game_session_ctrl_if #(
  parameter int TIME_W      = 16,
  parameter int SCORE_W     = 16,
  parameter int NUM_PLAYERS = 2
);
  import game_pkg::*;
  localparam int PW = idx_w(NUM_PLAYERS);
  logic                           start;
  logic                           increment_score;
  logic                           game_active;
  logic [TIME_W-1:0]              time_left;
  logic [PW-1:0]                  player_idx;
  logic [SCORE_W-1:0]             score;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_flat;
  logic                           game_over;
  logic [PW-1:0]                  winner_idx;
  logic [SCORE_W-1:0]             high_score;
  modport master (
    output start, increment_score,
    input  game_active, time_left, player_idx, score, scores_flat, game_over, winner_idx, high_score
  );
  modport slave (
    input  start, increment_score,
    output game_active, time_left, player_idx, score, scores_flat, game_over, winner_idx, high_score
  );
endinterface

// File: rtl/game_session_ctrl_pulse_sync.sv
// pulse_sync: two-flop synchronizer plus rising-edge detector, one pulse per input rise
module pulse_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);
  logic r_s1, r_s2, r_s3;
  // synchronize the async input and keep the previous synchronized value for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end
  assign pulse_out = r_s2 & ~r_s3;
endmodule

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: turn timer, per-player scoring and winner tracking; GAME_HIGH_SCORE_EN adds a high-score register
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int ROUND_SEC   = 60,
  parameter int TIME_W      = 16,
  parameter int SCORE_W     = 16,
  parameter int NUM_PLAYERS = 2
) (
  input logic clock,
  input logic reset,
  game_session_ctrl_if.slave bus
);
  localparam int PW   = idx_w(NUM_PLAYERS);
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  state_t             r_state;
  logic [PS_W-1:0]    r_ps;
  logic [TIME_W-1:0]  r_time;
  logic [PW-1:0]      r_player;
  logic [PW-1:0]      r_winner;
  logic               r_game_active;
  logic               r_game_over;
  logic [SCORE_W-1:0] r_scores [NUM_PLAYERS];
  logic [SCORE_W-1:0] w_next_scores [NUM_PLAYERS];
  logic [SCORE_W-1:0] w_cur;
  logic [SCORE_W-1:0] w_win_score;
  logic [PW-1:0]      w_win_idx;
  logic               w_pulse;
  logic               w_tick;
  logic               w_last_sec;
  logic               w_final;
  pulse_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.increment_score),
    .pulse_out(w_pulse)
  );
  assign w_tick     = (r_state == ST_PLAYING) && (r_ps == PS_W'(TICK_DIV - 1));
  assign w_last_sec = w_tick && (r_time == TIME_W'(1));
  assign w_final    = w_last_sec && (r_player == PW'(NUM_PLAYERS - 1));
  assign w_cur      = r_scores[r_player];
  // apply a saturating score increment, then pick the highest score (lowest index wins ties)
  always_comb begin
    w_next_scores = r_scores;
    if (w_pulse && r_state == ST_PLAYING)
      w_next_scores[r_player] = (&w_cur) ? w_cur : w_cur + 1'b1;
    w_win_idx   = '0;
    w_win_score = w_next_scores[0];
    for (int p = 1; p < NUM_PLAYERS; p++)
      if (w_next_scores[p] > w_win_score) begin
        w_win_score = w_next_scores[p];
        w_win_idx   = PW'(p);
      end
  end
  // session FSM with prescaler, turn timer, score array and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ps          <= '0;
      r_time        <= '0;
      r_player      <= '0;
      r_winner      <= '0;
      r_game_active <= 1'b0;
      r_game_over   <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAME_OVER: if (bus.start) begin
          r_state       <= ST_PLAYING;
          r_ps          <= '0;
          r_time        <= TIME_W'(ROUND_SEC);
          r_player      <= '0;
          r_game_active <= 1'b1;
          r_game_over   <= 1'b0;
          for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
        end
        ST_PLAYING: begin
          r_scores <= w_next_scores;
          r_ps     <= w_tick ? '0 : r_ps + 1'b1;
          if (w_tick) r_time <= r_time - 1'b1;
          if (w_last_sec) begin
            r_state       <= w_final ? ST_GAME_OVER : ST_TURN_END;
            r_game_active <= 1'b0;
            r_game_over   <= w_final;
            if (w_final) r_winner <= w_win_idx;
          end
        end
        ST_TURN_END: if (bus.start) begin
          r_state       <= ST_PLAYING;
          r_ps          <= '0;
          r_time        <= TIME_W'(ROUND_SEC);
          r_player      <= r_player + 1'b1;
          r_game_active <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`ifdef GAME_HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_high;
  // keep the best winning score of any completed game; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_high <= '0;
    else if (w_final && w_win_score > r_high) r_high <= w_win_score;
  end
  assign bus.high_score = r_high;
`else
  assign bus.high_score = '0;
`endif
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign bus.scores_flat[g*SCORE_W +: SCORE_W] = r_scores[g];
  end
  assign bus.game_active = r_game_active;
  assign bus.game_over   = r_game_over;
  assign bus.time_left   = r_time;
  assign bus.player_idx  = r_player;
  assign bus.winner_idx  = r_winner;
  assign bus.score       = w_cur;
endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: directed checks of timer, scoring, winner, high score and reset
module tb_game_session_ctrl;
`ifdef GAME_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total  = 0;
  int fails  = 0;
  always #5 clock = ~clock;
  game_session_ctrl_if #(.TIME_W(16), .SCORE_W(4), .NUM_PLAYERS(2)) bus ();
  game_session_ctrl_if #(.TIME_W(16), .SCORE_W(4), .NUM_PLAYERS(2)) bus2 ();
  game_session_ctrl #(.TICK_DIV(4), .ROUND_SEC(3), .TIME_W(16), .SCORE_W(4), .NUM_PLAYERS(2)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  game_session_ctrl #(.TICK_DIV(4), .ROUND_SEC(12), .TIME_W(16), .SCORE_W(4), .NUM_PLAYERS(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2.slave)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic start1();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  task automatic start2();
    bus2.start = 1'b1;
    tick(1);
    bus2.start = 1'b0;
  endtask
  task automatic pulse1();
    bus.increment_score = 1'b1;
    tick(1);
    bus.increment_score = 1'b0;
    tick(1);
  endtask
  task automatic pulse2();
    bus2.increment_score = 1'b1;
    tick(1);
    bus2.increment_score = 1'b0;
    tick(1);
  endtask
  // one full game on dut2 (48-cycle turns): player 0 scores n pulses, player 1 none
  task automatic play2(input int n, input logic [3:0] exp_p0, input logic [3:0] exp_hs, input string tag);
    start2();
    repeat (n) pulse2();
    tick(48 - 2 * n);
    start2();
    tick(48);
    check({tag, "_over"}, bus2.game_over, 1);
    check({tag, "_flat"}, bus2.scores_flat, {4'h0, exp_p0});
    check({tag, "_winner"}, bus2.winner_idx, 0);
    check({tag, "_high"}, bus2.high_score, HS_EN ? exp_hs : 4'h0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.increment_score = 1'b0;
    bus2.start = 1'b0;
    bus2.increment_score = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_active", bus.game_active, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_time", bus.time_left, 0);
    check("rst_player", bus.player_idx, 0);
    check("rst_flat", bus.scores_flat, 0);
    check("rst_winner", bus.winner_idx, 0);
    check("rst_high", bus.high_score, 0);
    tick(3);
    check("idle_holds", bus.game_active, 0);
    start1();
    check("start_active", bus.game_active, 1);
    check("start_time", bus.time_left, 3);
    tick(4);
    check("time_after4", bus.time_left, 2);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("start_ignored", bus.time_left, 2);
    tick(7);
    check("te_active", bus.game_active, 0);
    check("te_time", bus.time_left, 0);
    check("te_over", bus.game_over, 0);
    start1();
    check("t1_player", bus.player_idx, 1);
    check("t1_time", bus.time_left, 3);
    tick(12);
    check("g0_over", bus.game_over, 1);
    check("g0_winner", bus.winner_idx, 0);
    start1();
    repeat (5) pulse1();
    tick(2);
    check("five_te", bus.game_active, 0);
    check("five_score", bus.score, 5);
    start1();
    check("p1_score0", bus.score, 0);
    check("p1_idx", bus.player_idx, 1);
    pulse1();
    pulse1();
    tick(8);
    check("g1_over", bus.game_over, 1);
    check("g1_active", bus.game_active, 0);
    check("g1_flat", bus.scores_flat, 8'h25);
    check("g1_winner", bus.winner_idx, 0);
    check("g1_high", bus.high_score, HS_EN ? 5 : 0);
    start1();
    check("g2_cleared", bus.scores_flat, 0);
    check("g2_over_low", bus.game_over, 0);
    tick(9);
    bus.increment_score = 1'b1;
    tick(1);
    bus.increment_score = 1'b0;
    tick(2);
    check("final_tick_te", bus.game_active, 0);
    check("final_tick_cnt", bus.scores_flat, 8'h01);
    pulse1();
    tick(2);
    check("te_pulse_drop", bus.scores_flat, 8'h01);
    start1();
    bus.increment_score = 1'b1;
    tick(10);
    bus.increment_score = 1'b0;
    tick(2);
    check("held_over", bus.game_over, 1);
    check("held_once", bus.scores_flat, 8'h11);
    check("tie_winner", bus.winner_idx, 0);
    check("tie_high", bus.high_score, HS_EN ? 5 : 0);
    start1();
    pulse1();
    tick(10);
    start1();
    pulse1();
    pulse1();
    tick(8);
    check("p1win_flat", bus.scores_flat, 8'h21);
    check("p1win_winner", bus.winner_idx, 1);
    check("p1win_high", bus.high_score, HS_EN ? 5 : 0);
    play2(5, 4'd5, 4'd5, "hs_a");
    play2(3, 4'd3, 4'd5, "hs_b");
    play2(7, 4'd7, 4'd7, "hs_c");
    play2(20, 4'd15, 4'd15, "sat");
    start1();
    repeat (3) pulse1();
    tick(1);
    check("mid_score", bus.score, 3);
    check("mid_active", bus.game_active, 1);
    reset = 1'b1;
    #1;
    check("arst_active", bus.game_active, 0);
    check("arst_flat", bus.scores_flat, 0);
    check("arst_score", bus.score, 0);
    check("arst_time", bus.time_left, 0);
    check("arst_player", bus.player_idx, 0);
    check("arst_over", bus.game_over, 0);
    check("arst_high", bus.high_score, 0);
    check("arst_high2", bus2.high_score, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("arst_idle", bus.game_active, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
